qam16_upsampler: RTL and testbench

- Zero-stuffing interpolator for the QAM16 transmit chain.
- Takes the signed I/Q symbol levels from the symbol mapper, one new symbol per UP_FACTOR clocks. The symbol period is given by the counter output of the PRBS source.
- Emits each symbol on the phase-0 clock, then zeros on the remaining UP_FACTOR-1 clocks, producing a sample-rate stream for the pulse-shaping filter.

---
 rtl/qam16_pkg.sv | 15 +
 rtl/upsamp_lane.sv | 32 +++
 rtl/qam16_upsampler.sv | 54 +++++
 tb/tb_qam16_upsampler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/qam16_pkg.sv
// Shared QAM16 types and constants for the transmit chain.
package qam16_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_CNT_W  = 4;

    typedef logic signed [DEF_DATA_W-1:0] sym_t;

    localparam sym_t LVL_P3   = 4'sd3;
    localparam sym_t LVL_P1   = 4'sd1;
    localparam sym_t LVL_M1   = -4'sd1;
    localparam sym_t LVL_M3   = -4'sd3;
    localparam sym_t ZERO_SYM = '0;

endpackage

// File: rtl/upsamp_lane.sv
// One upsampler lane: loads the symbol on phase 0, otherwise zeros
// (or holds the last symbol when UPSAMPLER_HOLD_EN is defined).
module upsamp_lane
    import qam16_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_load,
    input  logic signed [DATA_W-1:0] i_d,
    output logic signed [DATA_W-1:0] o_q
);

    logic signed [DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
`ifndef UPSAMPLER_HOLD_EN
        else begin
            r_q <= '0;
        end
`endif
    end

    assign o_q = r_q;

endmodule

// File: rtl/qam16_upsampler.sv
// Zero-stuffing I/Q interpolator; phase taken from the low bits of the PRBS counter.
// Define UPSAMPLER_HOLD_EN for zero-order hold instead of zero insertion.
module qam16_upsampler
    import qam16_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int UP_FACTOR = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CNT_W-1:0]         count,
    input  logic signed [DATA_W-1:0] iout,
    input  logic signed [DATA_W-1:0] qout,
    output logic signed [DATA_W-1:0] iup,
    output logic signed [DATA_W-1:0] qup
);

    localparam int PH_W      = $clog2(UP_FACTOR);
    localparam int NUM_LANES = 2;

    if (UP_FACTOR < 2 || (1 << PH_W) != UP_FACTOR || PH_W > CNT_W) begin : g_bad_cfg
        $error("UP_FACTOR must be a power of two in [2, 2**CNT_W]");
    end

    logic                                w_phase0;
    logic [NUM_LANES-1:0][DATA_W-1:0]    w_din;
    logic [NUM_LANES-1:0][DATA_W-1:0]    w_dout;

    // Single phase decode shared by both lanes keeps I and Q in lockstep.
    assign w_phase0 = (count[PH_W-1:0] == '0);

    if (PH_W < CNT_W) begin : g_upper
        logic w_unused_cnt;
        assign w_unused_cnt = ^count[CNT_W-1:PH_W];
    end

    assign w_din[0] = iout;
    assign w_din[1] = qout;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        upsamp_lane #(.DATA_W(DATA_W)) u_lane (
            .clk    (clk),
            .rst_n  (reset),
            .i_load (w_phase0),
            .i_d    (w_din[g]),
            .o_q    (w_dout[g])
        );
    end

    assign iup = w_dout[0];
    assign qup = w_dout[1];

endmodule

// File: tb/tb_qam16_upsampler.sv
// Randomised and directed bench for qam16_upsampler against a behavioural model.
module tb_qam16_upsampler;

    localparam int DW = 4;
    localparam int CW = 4;
    localparam int UF = 4;

    logic                 clk   = 1'b0;
    logic                 reset = 1'b0;
    logic [CW-1:0]        count = '0;
    logic signed [DW-1:0] iout  = '0;
    logic signed [DW-1:0] qout  = '0;
    logic signed [DW-1:0] iup;
    logic signed [DW-1:0] qup;

    int checks = 0;
    int errors = 0;

`ifdef UPSAMPLER_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    qam16_upsampler #(.DATA_W(DW), .CNT_W(CW), .UP_FACTOR(UF)) dut (
        .clk   (clk),
        .reset (reset),
        .count (count),
        .iout  (iout),
        .qout  (qout),
        .iup   (iup),
        .qup   (qup)
    );

    always #5 clk = ~clk;

    // Reference: sample on count mod UF == 0, otherwise zero (or keep, in hold mode).
    logic signed [DW-1:0] m_i = '0;
    logic signed [DW-1:0] m_q = '0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_i <= '0;
            m_q <= '0;
        end else if ((int'(count) % UF) == 0) begin
            m_i <= iout;
            m_q <= qout;
        end else if (!HOLD) begin
            m_i <= '0;
            m_q <= '0;
        end
    end

    // Drive inputs just after an edge, then advance to 1 time unit past the next edge.
    task automatic drive(input int c, input int i, input int q);
        count = CW'(c);
        iout  = DW'(i);
        qout  = DW'(q);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        count = '0;
        iout  = 4'sd3;
        qout  = -4'sd3;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (iup !== 4'sd0 || qup !== 4'sd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d iup=%0d qup=%0d exp=0/0", k, iup, qup);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int ei, eq;
        for (int p = 0; p < 8; p++) begin
            if (p % 4 == 0) drive(p % 4, 3, -1);
            else            drive(p % 4, $urandom_range(0, 15), $urandom_range(0, 15));
            ei = (p % 4 == 0 || HOLD) ? 3 : 0;
            eq = (p % 4 == 0 || HOLD) ? -1 : 0;
            checks++;
            if (iup !== DW'(ei) || qup !== DW'(eq) || iup !== m_i || qup !== m_q) begin
                errors++;
                $display("FAIL basic p%0d iup=%0d qup=%0d exp=%0d/%0d", p, iup, qup, ei, eq);
            end
        end
    endtask

    task automatic test_symbol_change();
        int ei, eq;
        for (int p = 0; p < 8; p++) begin
            if (p == 0)      drive(0, 1, -3);
            else if (p == 4) drive(0, -3, 1);
            else             drive(p % 4, $urandom_range(0, 15), $urandom_range(0, 15));
            ei = 0;
            eq = 0;
            if (p == 0 || (HOLD && p < 4)) begin ei = 1;  eq = -3; end
            if (p == 4 || (HOLD && p > 4)) begin ei = -3; eq = 1;  end
            checks++;
            if (iup !== DW'(ei) || qup !== DW'(eq)) begin
                errors++;
                $display("FAIL symchg p%0d iup=%0d qup=%0d exp=%0d/%0d", p, iup, qup, ei, eq);
            end
        end
    endtask

    task automatic test_glitch();
        int ei;
        int seq [5] = '{1, 1, -1, -1, 3};
        for (int p = 0; p < 5; p++) begin
            drive(p % 4, seq[p], 0);
            ei = (p == 0 || (HOLD && p < 4)) ? 1 : (p == 4 ? 3 : 0);
            checks++;
            if (iup !== DW'(ei) || iup !== m_i) begin
                errors++;
                $display("FAIL glitch p%0d iup=%0d exp=%0d", p, iup, ei);
            end
        end
    endtask

    task automatic test_wrap_extreme();
        int cnts [6] = '{12, 13, 14, 15, 0, 1};
        int ivs  [6] = '{-8, 2, 3, 4, 5, 6};
        int qvs  [6] = '{7, -2, -3, -4, -8, -6};
        int ei, eq;
        for (int p = 0; p < 6; p++) begin
            drive(cnts[p], ivs[p], qvs[p]);
            if (p < 4) begin
                ei = (p == 0 || HOLD) ? -8 : 0;
                eq = (p == 0 || HOLD) ? 7  : 0;
            end else begin
                ei = (p == 4 || HOLD) ? 5  : 0;
                eq = (p == 4 || HOLD) ? -8 : 0;
            end
            checks++;
            if (iup !== DW'(ei) || qup !== DW'(eq)) begin
                errors++;
                $display("FAIL wrap cnt%0d iup=%b qup=%b exp=%b/%b", cnts[p], iup, qup, DW'(ei), DW'(eq));
            end
        end
    endtask

    task automatic test_async_reset();
        drive(0, 3, -3);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (iup !== 4'sd0 || qup !== 4'sd0) begin
            errors++;
            $display("FAIL async_rst iup=%0d qup=%0d exp=0/0", iup, qup);
        end
        drive(0, 5, 6);
        checks++;
        if (iup !== 4'sd0 || qup !== 4'sd0) begin
            errors++;
            $display("FAIL rst_held iup=%0d qup=%0d exp=0/0", iup, qup);
        end
        #2 reset = 1'b1;
        drive(8, -7, 2);
        checks++;
        if (iup !== -4'sd7 || qup !== 4'sd2) begin
            errors++;
            $display("FAIL rst_release iup=%0d qup=%0d exp=-7/2", iup, qup);
        end
    endtask

    task automatic test_random();
        int c;
        c = 0;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 7) == 0) c = $urandom_range(0, 15);
            else                           c = (c + 1) % 16;
            drive(c, $urandom_range(0, 15), $urandom_range(0, 15));
            checks++;
            if (iup !== m_i || qup !== m_q) begin
                errors++;
                $display("FAIL random k%0d cnt=%0d iup=%0d qup=%0d exp=%0d/%0d", k, c, iup, qup, m_i, m_q);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_symbol_change();
        test_glitch();
        test_wrap_extreme();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
